// File: rtl/fetch_to_decode_queue_if.sv
// Fetch-to-decode handshake bundle.
//   send_*  : fetch side (valid/ready/data into the queue)
//   recv_*  : decode side (valid/ready/data out of the queue)
// Modports:
//   slave  : the queue itself
//   master : the environment driving fetch and decode
interface fetch_to_decode_queue_if #(
   parameter int unsigned PKT_W = 64
);
   logic             send_valid;
   logic             send_ready;
   logic [PKT_W-1:0] send_data;
   logic             recv_valid;
   logic             recv_ready;
   logic [PKT_W-1:0] recv_data;

   modport slave (
      input  send_valid, send_data, recv_ready,
      output send_ready, recv_valid, recv_data
   );

   modport master (
      output send_valid, send_data, recv_ready,
      input  send_ready, recv_valid, recv_data
   );
endinterface

// File: rtl/fetch_to_decode_queue.sv
// DEPTH-entry circular FIFO carrying fetch packets (PC + instruction) to decode.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   flush        : synchronous discard of all entries (redirect / exception)
//   bus          : valid/ready send side and recv side (slave modport)
//   count        : current occupancy, 0..DEPTH
//   is_busy      : count != 0
//   almost_full  : count >= AF_LEVEL
//   proto_err    : sticky flag, set when fetch withdraws or alters an unaccepted offer
module fetch_to_decode_queue #(
   parameter int unsigned PKT_W    = 64,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   fetch_to_decode_queue_if.slave       bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         is_busy,
   output logic                         almost_full,
   output logic                         proto_err
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PKT_W-1:0] mem_q [DEPTH];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             proto_err_q, proto_err_d;

   // Registered copy of last cycle's offer for the hold-stable check.
   logic             prev_valid_q;
   logic             prev_acc_q;
   logic             prev_flush_q;
   logic [PKT_W-1:0] prev_data_q;

   logic push, pop, full, empty, violation;

   // Ready/valid depend only on registered count: no ready-through path on a full pop.
   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);

   assign bus.send_ready = !full;
   assign bus.recv_valid = !empty;
   assign bus.recv_data  = mem_q[rd_ptr_q];

   assign push = bus.send_valid && bus.send_ready;
   assign pop  = bus.recv_valid && bus.recv_ready;

   assign count       = count_q;
   assign is_busy     = !empty;
   assign almost_full = (count_q >= CntW'(AF_LEVEL));
   assign proto_err   = proto_err_q;

   // An unaccepted offer must be held with identical data, unless a flush intervenes.
   assign violation = prev_valid_q && !prev_acc_q && !prev_flush_q && !flush &&
                      (!bus.send_valid || (bus.send_data != prev_data_q));

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      proto_err_d = proto_err_q || violation;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         proto_err_q  <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_acc_q   <= 1'b0;
         prev_flush_q <= 1'b0;
         prev_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         proto_err_q  <= proto_err_d;
         prev_valid_q <= bus.send_valid;
         prev_acc_q   <= push;
         prev_flush_q <= flush;
         prev_data_q  <= bus.send_data;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= bus.send_data;
      end
   end
endmodule

// File: tb/tb_fetch_to_decode_queue.sv
module tb_fetch_to_decode_queue;
   localparam int unsigned PKT_W = 64;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] count;
   logic       is_busy, almost_full, proto_err;

   fetch_to_decode_queue_if #(.PKT_W(PKT_W)) bus ();

   fetch_to_decode_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .count       (count),
      .is_busy     (is_busy),
      .almost_full (almost_full),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;
   logic [PKT_W-1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Advance one edge; inputs change and checks happen 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [PKT_W-1:0] d);
      exp_q.push_back(d);
   endtask

   // Monitor: at the falling edge, a head that will be consumed at the next rising edge
   // is compared with the oldest expected packet.
   always @(negedge clk) begin
      if (rst_n && !flush && bus.recv_valid && bus.recv_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", bus.recv_data, 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            check("pop_data", bus.recv_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.send_valid = 1'b0;
      bus.send_data  = '0;
      bus.recv_ready = 1'b0;

      // 1. Reset then idle
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("rst_count", 64'(count), 0);
      check("rst_send_ready", 64'(bus.send_ready), 1);
      check("rst_recv_valid", 64'(bus.recv_valid), 0);
      check("rst_is_busy", 64'(is_busy), 0);
      check("rst_almost_full", 64'(almost_full), 0);
      check("rst_proto_err", 64'(proto_err), 0);

      // 2. Fill then drain
      begin
         logic [PKT_W-1:0] fill [4];
         fill = '{64'h11, 64'h22, 64'h33, 64'h44};
         for (int i = 0; i < 4; i++) begin
            bus.send_valid = 1'b1;
            bus.send_data  = fill[i];
            push_exp(fill[i]);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_almost_full", 64'(almost_full), (i + 1 >= 3) ? 64'd1 : 64'd0);
         end
      end
      bus.send_valid = 1'b0;
      check("full_send_ready", 64'(bus.send_ready), 0);
      check("full_is_busy", 64'(is_busy), 1);
      bus.recv_ready = 1'b1;
      repeat (4) step();
      bus.recv_ready = 1'b0;
      check("drain_count", 64'(count), 0);
      check("drain_recv_valid", 64'(bus.recv_valid), 0);

      // 3. Simultaneous push/pop across the pointer wrap
      bus.send_valid = 1'b1;
      bus.send_data  = 64'd1;
      push_exp(64'd1);
      step();
      bus.recv_ready = 1'b1;
      for (int i = 2; i <= 11; i++) begin
         bus.send_data = 64'(i);
         push_exp(64'(i));
         step();
         check("wrap_count", 64'(count), 1);
      end
      bus.send_valid = 1'b0;
      step();
      bus.recv_ready = 1'b0;
      check("wrap_drained", 64'(count), 0);

      // 4. Full with pop: no ready-through
      for (int i = 0; i < 4; i++) begin
         bus.send_valid = 1'b1;
         bus.send_data  = 64'hA1 + 64'(i);
         push_exp(64'hA1 + 64'(i));
         step();
      end
      bus.send_data  = 64'h55;
      bus.recv_ready = 1'b1;
      check("fullpop_send_ready", 64'(bus.send_ready), 0);
      step();
      check("fullpop_count", 64'(count), 3);
      bus.recv_ready = 1'b0;
      push_exp(64'h55);
      step();
      bus.send_valid = 1'b0;
      check("fullpop_final_count", 64'(count), 4);
      check("fullpop_no_err", 64'(proto_err), 0);
      bus.recv_ready = 1'b1;
      repeat (4) step();
      bus.recv_ready = 1'b0;
      check("fullpop_drained", 64'(count), 0);

      // 5. Flush mid-stream with a concurrent push of 0x99
      for (int i = 0; i < 3; i++) begin
         bus.send_valid = 1'b1;
         bus.send_data  = 64'h61 + 64'(i);
         push_exp(64'h61 + 64'(i));
         step();
      end
      bus.send_data = 64'h99;
      flush = 1'b1;
      step();
      exp_q.delete();
      flush = 1'b0;
      bus.send_valid = 1'b0;
      check("flush_count", 64'(count), 0);
      check("flush_recv_valid", 64'(bus.recv_valid), 0);
      bus.recv_ready = 1'b1;
      repeat (2) step();
      bus.recv_ready = 1'b0;
      check("flush_still_empty", 64'(bus.recv_valid), 0);
      check("flush_no_err", 64'(proto_err), 0);

      // 6. Protocol violation, then asynchronous reset between edges
      for (int i = 0; i < 4; i++) begin
         bus.send_valid = 1'b1;
         bus.send_data  = 64'hB1 + 64'(i);
         push_exp(64'hB1 + 64'(i));
         step();
      end
      bus.send_data = 64'hAA;
      step();
      check("held_no_err", 64'(proto_err), 0);
      bus.send_data = 64'hBB;
      step();
      check("viol_err", 64'(proto_err), 1);
      bus.send_valid = 1'b0;
      step();
      check("viol_sticky", 64'(proto_err), 1);
      check("viol_count", 64'(count), 4);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_proto_err", 64'(proto_err), 0);
      check("arst_count", 64'(count), 0);
      check("arst_recv_valid", 64'(bus.recv_valid), 0);
      check("arst_send_ready", 64'(bus.send_ready), 1);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("post_rst_err", 64'(proto_err), 0);
      check("leftover_expected", 64'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
